// File: rtl/parser_pkg.sv
// Shared widths, types and the range check for the parser field-extraction lanes.
package parser_pkg;

   localparam int CANDI_NUM    = 128;
   localparam int OFFSET_WIDTH = 7;
   localparam int FIELD_BYTES  = 4;
   localparam int LEN_WIDTH    = 3;

   typedef logic [7:0]               byte_t;
   typedef logic [OFFSET_WIDTH:0]    offset_t;   // {enable, byte index}
   typedef logic [LEN_WIDTH-1:0]     len_t;
   typedef logic [FIELD_BYTES*8-1:0] field_t;

   // True when the whole field fits in the window and the length is legal.
   function automatic logic field_in_range(input logic [OFFSET_WIDTH-1:0] off, input len_t len);
      logic [OFFSET_WIDTH+1:0] end_pos;
      end_pos = {2'b00, off} + {{(OFFSET_WIDTH+2-LEN_WIDTH){1'b0}}, len};
      return (end_pos <= (OFFSET_WIDTH+2)'(CANDI_NUM)) && (len <= LEN_WIDTH'(FIELD_BYTES));
   endfunction

endpackage

// File: rtl/extract_field_lane.sv
// One extraction lane: stage 1 grabs the raw bytes at the offset, stage 2
// right-aligns them in network order and masks disabled or out-of-range fields.
module extract_field_lane
   import parser_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_ld1,
   input  logic                    i_ld2,
   input  byte_t [CANDI_NUM-1:0]   i_data,
   input  offset_t                 i_offset,
   input  len_t                    i_len,
   output field_t                  o_field,
   output logic                    o_err
);
   localparam int SELW = (FIELD_BYTES > 1) ? $clog2(FIELD_BYTES) : 1;

   byte_t [FIELD_BYTES-1:0] bytes_d, bytes_q;
   byte_t [FIELD_BYTES-1:0] field_d;
   field_t                  field_q;
   len_t                    len_q;
   logic                    en_d, en_q;
   logic                    err_d, err_q;
   logic                    err2_q;

   // Bytes past the end of the window read as zero rather than wrapping.
   for (genvar j = 0; j < FIELD_BYTES; j++) begin : g_sel
      logic [OFFSET_WIDTH:0] idx;
      assign idx        = {1'b0, i_offset[OFFSET_WIDTH-1:0]} + (OFFSET_WIDTH+1)'(j);
      assign bytes_d[j] = (idx < (OFFSET_WIDTH+1)'(CANDI_NUM)) ? i_data[idx[OFFSET_WIDTH-1:0]] : '0;
   end

   assign en_d  = i_offset[OFFSET_WIDTH];
   assign err_d = en_d && (i_len != '0) && !field_in_range(i_offset[OFFSET_WIDTH-1:0], i_len);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         bytes_q <= '0;
         en_q    <= 1'b0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else if (i_ld1) begin
         bytes_q <= bytes_d;
         en_q    <= en_d;
         len_q   <= i_len;
         err_q   <= err_d;
      end
   end

   // Output byte k takes captured byte len-1-k, so the first wire byte lands highest.
   for (genvar k = 0; k < FIELD_BYTES; k++) begin : g_align
      logic [SELW-1:0] sel;
      assign sel        = SELW'(len_q - LEN_WIDTH'(k + 1));
      assign field_d[k] = (en_q && !err_q && (LEN_WIDTH'(k) < len_q)) ? bytes_q[sel] : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         field_q <= '0;
         err2_q  <= 1'b0;
      end else if (i_ld2) begin
         field_q <= field_d;
         err2_q  <= err_q;
      end
   end

   assign o_field = field_q;
   assign o_err   = err2_q;

endmodule

// File: rtl/extract_field_array.sv
// Two-stage valid/ready field extractor: FIELD_NUM parallel lanes plus
// sideband metadata and a saturating per-beat error counter.
module extract_field_array #(
   parameter int CANDI_NUM    = parser_pkg::CANDI_NUM,
   parameter int OFFSET_WIDTH = parser_pkg::OFFSET_WIDTH,
   parameter int FIELD_NUM    = 4,
   parameter int FIELD_BYTES  = parser_pkg::FIELD_BYTES,
   parameter int LEN_WIDTH    = parser_pkg::LEN_WIDTH,
   parameter int META_WIDTH   = 16,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                                     i_clk,
   input  logic                                     i_rst_n,
   input  logic                                     i_valid,
   output logic                                     o_ready,
   input  logic [CANDI_NUM-1:0][7:0]                i_data,
   input  logic [FIELD_NUM-1:0][OFFSET_WIDTH:0]     i_offset,
   input  logic [FIELD_NUM-1:0][LEN_WIDTH-1:0]      i_len,
   input  logic [META_WIDTH-1:0]                    i_meta,
   output logic                                     o_valid,
   input  logic                                     i_ready,
   output logic [FIELD_NUM-1:0][FIELD_BYTES*8-1:0]  o_field,
   output logic [FIELD_NUM-1:0]                     o_err,
   output logic [META_WIDTH-1:0]                    o_meta,
   output logic [CNT_WIDTH-1:0]                     o_err_cnt
);
   import parser_pkg::*;

   logic                  s1_v_d, s1_v_q;
   logic                  s2_v_d, s2_v_q;
   logic [META_WIDTH-1:0] meta1_q, meta2_q;
   logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
   logic                  s2_free, s1_free;
   logic                  in_fire, out_fire, ld2;

   assign s2_free  = !s2_v_q || i_ready;
   assign s1_free  = !s1_v_q || s2_free;
   assign o_ready  = s1_free;
   assign in_fire  = i_valid && o_ready;
   assign out_fire = s2_v_q && i_ready;
   assign ld2      = s1_v_q && s2_free;

   always_comb begin
      s1_v_d = s1_v_q;
      s2_v_d = s2_v_q;
      cnt_d  = cnt_q;
      if (s2_free)
         s2_v_d = s1_v_q;
      if (in_fire)
         s1_v_d = 1'b1;
      else if (s2_free)
         s1_v_d = 1'b0;
      if (out_fire && (|o_err) && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s1_v_q  <= 1'b0;
         s2_v_q  <= 1'b0;
         meta1_q <= '0;
         meta2_q <= '0;
         cnt_q   <= '0;
      end else begin
         s1_v_q <= s1_v_d;
         s2_v_q <= s2_v_d;
         cnt_q  <= cnt_d;
         if (in_fire)
            meta1_q <= i_meta;
         if (ld2)
            meta2_q <= meta1_q;
      end
   end

   for (genvar g = 0; g < FIELD_NUM; g++) begin : g_lane
      extract_field_lane u_lane (
         .i_clk    (i_clk),
         .i_rst_n  (i_rst_n),
         .i_ld1    (in_fire),
         .i_ld2    (ld2),
         .i_data   (i_data),
         .i_offset (i_offset[g]),
         .i_len    (i_len[g]),
         .o_field  (o_field[g]),
         .o_err    (o_err[g])
      );
   end

   assign o_valid   = s2_v_q;
   assign o_meta    = meta2_q;
   assign o_err_cnt = cnt_q;

endmodule

// File: tb/tb_extract_field_array.sv
// Scoreboard bench for extract_field_array: stimulus pushes expected beats,
// a negedge monitor compares whatever the DUT presents.
module tb_extract_field_array;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  i_valid = 1'b0;
   logic                  o_ready;
   logic [127:0][7:0]     i_data = '0;
   logic [3:0][7:0]       i_offset = '0;
   logic [3:0][2:0]       i_len = '0;
   logic [15:0]           i_meta = '0;
   logic                  o_valid;
   logic                  i_ready = 1'b1;
   logic [3:0][31:0]      o_field;
   logic [3:0]            o_err;
   logic [15:0]           o_meta;
   logic [3:0]            o_err_cnt;

   typedef struct {
      logic [3:0][31:0] f;
      logic [3:0]       e;
      logic [15:0]      m;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   model_cnt = 0;
   logic [127:0][7:0] win1, win2;

   extract_field_array #(.CNT_WIDTH(4)) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_valid   (i_valid),
      .o_ready   (o_ready),
      .i_data    (i_data),
      .i_offset  (i_offset),
      .i_len     (i_len),
      .i_meta    (i_meta),
      .o_valid   (o_valid),
      .i_ready   (i_ready),
      .o_field   (o_field),
      .o_err     (o_err),
      .o_meta    (o_meta),
      .o_err_cnt (o_err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   function automatic exp_t mk(input logic [3:0][31:0] f, input logic [3:0] e, input logic [15:0] m);
      exp_t r;
      r.f = f;
      r.e = e;
      r.m = m;
      return r;
   endfunction

   // Reference: concatenate wire bytes one at a time, MSB first.
   function automatic exp_t model(input logic [127:0][7:0] win, input logic [3:0][7:0] off,
                                  input logic [3:0][2:0] len, input logic [15:0] meta);
      exp_t r;
      r.f = '0;
      r.e = '0;
      r.m = meta;
      for (int l = 0; l < 4; l++) begin
         int o;
         int n;
         o = int'(off[l][6:0]);
         n = int'(len[l]);
         if (off[l][7] && n != 0) begin
            if (o + n > 128 || n > 4)
               r.e[l] = 1'b1;
            else
               for (int j = 0; j < n; j++)
                  r.f[l] = {r.f[l][23:0], win[o + j]};
         end
      end
      return r;
   endfunction

   task automatic send(input logic [127:0][7:0] win, input logic [3:0][7:0] off,
                       input logic [3:0][2:0] len, input logic [15:0] meta,
                       input exp_t e, output bit first_try);
      int  waited;
      bit  acc;
      waited   = 0;
      acc      = 1'b0;
      i_data   = win;
      i_offset = off;
      i_len    = len;
      i_meta   = meta;
      i_valid  = 1'b1;
      sb.push_back(e);
      do begin
         @(negedge clk);
         acc = o_ready;
         @(posedge clk);
         #1;
         waited++;
      end while (!acc && waited < 100);
      first_try = (waited == 1);
      if (!acc)
         fail("accept_timeout");
      i_valid = 1'b0;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      if (sb.size() != 0)
         fail("drain_timeout");
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (rst_n && o_valid) begin
         if (sb.size() == 0) begin
            fail("unexpected_beat");
         end else begin
            cur = sb[0];
            check("field", o_field, cur.f);
            check("err", o_err, cur.e);
            check("meta", o_meta, cur.m);
            if (i_ready) begin
               check("err_cnt", o_err_cnt, model_cnt);
               if (|cur.e && model_cnt < 15)
                  model_cnt++;
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit ft;
      for (int k = 0; k < 128; k++) begin
         win1[k] = 8'(k);
         win2[k] = 8'(255 - k);
      end

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", o_valid, 0);
      check("rst_field", o_field, 0);
      check("rst_err", o_err, 0);
      check("rst_meta", o_meta, 0);
      check("rst_cnt", o_err_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic extraction and two-cycle latency
      send(win1, {8'hFF, 8'h05, 8'h80, 8'h8C}, {3'd1, 3'd4, 3'd1, 3'd4}, 16'hA001,
           mk({32'h0000007F, 32'h0, 32'h0, 32'h0C0D0E0F}, 4'b0000, 16'hA001), ft);
      @(negedge clk);
      check("lat_one_cycle", o_valid, 0);
      @(negedge clk);
      check("lat_two_cycle", o_valid, 1);
      check("lat_cnt", o_err_cnt, 0);
      @(posedge clk);
      #1;

      // window end, overrun, illegal length, zero length, exact fit
      send(win1, {8'h00, 8'h00, 8'h00, 8'hFE}, {3'd0, 3'd0, 3'd0, 3'd2}, 16'hA002,
           mk({32'h0, 32'h0, 32'h0, 32'h00007E7F}, 4'b0000, 16'hA002), ft);
      check("tput_a", ft, 1);
      send(win1, {8'h00, 8'h00, 8'h00, 8'hFE}, {3'd0, 3'd0, 3'd0, 3'd4}, 16'hA003,
           mk({32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 16'hA003), ft);
      check("tput_b", ft, 1);
      send(win1, {8'hFD, 8'h8A, 8'h80, 8'h81}, {3'd3, 3'd0, 3'd5, 3'd3}, 16'hA004,
           mk({32'h007D7E7F, 32'h0, 32'h0, 32'h00010203}, 4'b0010, 16'hA004), ft);
      check("tput_c", ft, 1);
      drain();
      check("cnt_after_errs", o_err_cnt, 2);

      // burst of 5 against a stalled sink
      i_ready = 1'b0;
      fork
         begin
            bit f2;
            for (int i = 1; i <= 5; i++) begin
               logic [3:0][7:0] off;
               logic [3:0][2:0] len;
               off = {8'h80 | 8'(i), 8'(i * 9), 8'h80 | 8'(120 + i), 8'h80 | 8'(i * 20)};
               len = {3'd2, 3'd4, 3'd4, 3'(i % 5)};
               send(win2, off, len, 16'(i), model(win2, off, len, 16'(i)), f2);
            end
         end
         begin
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("stall_oready", o_ready, 0);
            @(posedge clk);
            #1;
            i_ready = 1'b1;
         end
      join
      drain();

      // fill both stages, then stream with simultaneous accept and drain
      i_ready = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic [3:0][7:0] off;
         logic [3:0][2:0] len;
         off = {8'h80 | 8'(i * 10), 8'h80 | 8'(i), 8'h80 | 8'(100 + i), 8'h80 | 8'(i * 3)};
         len = {3'(i % 4 + 1), 3'd1, 3'd3, 3'd4};
         send(win1, off, len, 16'h0100 + 16'(i), model(win1, off, len, 16'h0100 + 16'(i)), ft);
         if (i == 1)
            i_ready = 1'b1;
         if (i >= 2)
            check("full_tput", ft, 1);
      end
      drain();

      // asynchronous reset with two beats in flight
      i_ready = 1'b0;
      send(win1, {8'h00, 8'h00, 8'h00, 8'hFF}, {3'd0, 3'd0, 3'd0, 3'd4}, 16'h0200,
           mk({32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 16'h0200), ft);
      send(win1, {8'h00, 8'h00, 8'h00, 8'h84}, {3'd0, 3'd0, 3'd0, 3'd1}, 16'h0201,
           mk({32'h0, 32'h0, 32'h0, 32'h4}, 4'b0000, 16'h0201), ft);
      #3;
      rst_n = 1'b0;
      sb.delete();
      model_cnt = 0;
      #1;
      check("arst_valid", o_valid, 0);
      check("arst_cnt", o_err_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      i_ready = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("post_rst_valid", o_valid, 0);
      check("post_rst_cnt", o_err_cnt, 0);
      @(posedge clk);
      #1;

      // error counter saturation
      for (int i = 0; i < 20; i++)
         send(win1, {8'h00, 8'h00, 8'h00, 8'hFF}, {3'd0, 3'd0, 3'd0, 3'd2}, 16'h0300 + 16'(i),
              mk({32'h0, 32'h0, 32'h0, 32'h0}, 4'b0001, 16'h0300 + 16'(i)), ft);
      drain();
      check("cnt_saturated", o_err_cnt, 15);
      check("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/extract_field_array.md
Name: extract_field_array

Overview:
- Multi-lane, pipelined field extractor for the parser stage.
- Each transaction presents a CANDI_NUM-byte header window. The block pulls FIELD_NUM fields from it in parallel.
- Each field is up to FIELD_BYTES consecutive bytes, at a per-field offset and length.
- valid/ready handshakes on both sides, two register stages, per-field range checking, and a saturating error counter.

Parameters:
- CANDI_NUM, 128: bytes in the header window.
- OFFSET_WIDTH, 7: offset index width; must equal clog2(CANDI_NUM).
- FIELD_NUM, 4: number of parallel extraction lanes.
- FIELD_BYTES, 4: maximum field length in bytes; output lane width is FIELD_BYTES*8.
- LEN_WIDTH, 3: length width; must equal clog2(FIELD_BYTES+1).
- META_WIDTH, 16: sideband metadata carried alongside the data, unmodified.
- CNT_WIDTH, 16: width of the error counter.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_valid, in, 1: input beat valid.
- o_ready, out, 1: block can accept a beat.
- i_data, in, [CANDI_NUM-1:0][7:0]: header window; byte 0 is the first byte on the wire.
- i_offset, in, [FIELD_NUM-1:0][OFFSET_WIDTH:0]: per-lane offset; the top bit is the lane enable.
- i_len, in, [FIELD_NUM-1:0][LEN_WIDTH-1:0]: per-lane length in bytes, 0..FIELD_BYTES.
- i_meta, in, META_WIDTH: sideband.
- o_valid, out, 1: output beat valid.
- i_ready, in, 1: downstream accepts.
- o_field, out, [FIELD_NUM-1:0][FIELD_BYTES*8-1:0]: extracted fields.
- o_err, out, FIELD_NUM: per-lane out-of-range flag.
- o_meta, out, META_WIDTH: sideband.
- o_err_cnt, out, CNT_WIDTH: saturating count of beats with any error flag set.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n. Reset clears both stage valid bits and the error counter.
  - At reset, o_valid=0, o_field=0, o_err=0, o_meta=0, o_err_cnt=0.
  - Reset mid-operation drops in-flight beats; no partial output after release.
- Handshake:
  - A beat transfers on the input when i_valid & o_ready, and on the output when o_valid & i_ready.
  - Each stage loads when it is empty or its downstream stage moves in the same cycle.
  - o_ready = !s1_v | !s2_v | i_ready, combinational and bubble-collapsing.
  - o_valid and the output data hold stable while o_valid & !i_ready.
- Latency: 2 cycles from input acceptance to o_valid with no backpressure. Throughput is 1 beat per cycle.
- Stage 1, per lane, registered:
  - Capture bytes i_data[off .. off+FIELD_BYTES-1]. Byte indices >= CANDI_NUM read as 0; there is no wrap-around.
  - Capture en, len and a range error flag. The error is (off + len > CANDI_NUM), evaluated unsigned at OFFSET_WIDTH+2 bits.
  - Capture i_meta.
- Stage 2, registered, network order, right-aligned:
  - For len=L, byte off lands at bit position (L-1)*8 and byte off+L-1 in bits [7:0]. Bits above L*8 are zero.
  - en=0 or L=0: field=0, err=0.
  - Range error: field=0, err=1.
  - L > FIELD_BYTES: treated as a range error.
- Error counter:
  - Increments by 1 at output transfer when |o_err is set.
  - Saturates at all-ones.
  - Counts once per beat, not per lane.
- Simultaneous input and output transfer with both stages full: the pipeline shifts; no beat is lost or duplicated.

Decomposition:
- Package parser_pkg holds:
  - Parameter defaults: CANDI_NUM, FIELD_BYTES, OFFSET_WIDTH.
  - typedefs: byte_t, offset_t (enable bit plus index), len_t, field_t.
  - Function field_in_range(off, len).
- Sub-module extract_field_lane: one lane covering the stage-1 byte select and the stage-2 alignment and masking. Generated FIELD_NUM times.
- The top level owns the handshake, the stage valid bits, the metadata and the counter.

Test Plan:
- Window byte k = k. Lane 0 off=12 en len=4; lane 1 off=0 en len=1; lane 2 en=0; lane 3 off=127 len=1 -> two cycles later:
  - o_field = {0x0C0D0E0F, 0x00000000, 0x00000000, 0x0000007F} for lanes 0, 1, 2, 3. Lane 1 is 0 because byte 0 holds 0x00.
  - o_err=0, o_err_cnt=0.
- Lane 0 off=126 len=2 -> 0x00007E7F, err0=0. Next beat, lane 0 off=126 len=4 -> field 0, err0=1, o_err_cnt=1.
- Burst of 5 beats with meta 1..5 and i_ready=0 for cycles 2-5:
  - o_ready drops after 2 beats are buffered.
  - After i_ready returns, outputs arrive in order with meta 1..5 and no loss.
  - Output is stable while stalled.
- Simultaneous accept and drain with both stages full for 10 cycles -> 1 beat/cycle, order preserved.
- Assert i_rst_n low with 2 beats in flight -> o_valid=0 immediately (asynchronous). After release, no stale beat appears and o_err_cnt=0.
- CNT_WIDTH=4, 20 error beats -> o_err_cnt saturates at 15.
